pixel_stream_unpacker: RTL and testbench
========================================

PIXEL_STREAM_UNPACKER -- requirements
Module: pixel_stream_unpacker

Interface
REQ-001 SHALL have parameter SUB_PIXEL_WIDTH, default 4: stored sub-pixel width in bits.
REQ-002 SHALL have parameter CONV_SUB_PIXEL_WIDTH, default 8: expanded sub-pixel width; must be >= SUB_PIXEL_WIDTH.
REQ-003 SHALL have parameter NUMBER_OF_SUB_PIXELS, default 4: sub-pixels per pixel.
REQ-004 SHALL have parameter STREAM_WIDTH, default 64: input word width; must be an integer multiple of PIXEL_WIDTH (SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS); PIXELS_PER_BEAT = STREAM_WIDTH/PIXEL_WIDTH.
REQ-005 SHALL have port aclk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports s_axis_tvalid/s_axis_tready/s_axis_tlast (1 each) and s_axis_tdata (STREAM_WIDTH): packed reduced-pixel input stream, AXI-Stream semantics.
REQ-008 SHALL have ports m_axis_tvalid/m_axis_tready/m_axis_tlast (1 each) and m_axis_tdata (CONV_SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS): one expanded pixel per beat.

Function
REQ-009 SHALL accept an input word only on s_axis_tvalid && s_axis_tready, latching data and tlast into an unpack register with pixel index 0.
REQ-010 SHALL emit pixels of a word in ascending order, pixel k = s_axis_tdata[k*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-011 SHALL expand each sub-pixel i as {c, c[SUB_PIXEL_WIDTH-1 -: DIFF]} (MSB replication, DIFF = CONV_SUB_PIXEL_WIDTH - SUB_PIXEL_WIDTH), placed at bit i*CONV_SUB_PIXEL_WIDTH; when DIFF = 0 the pixel passes unchanged.
REQ-012 SHALL drive m_axis_tdata/m_axis_tvalid/m_axis_tlast from registers; first pixel appears 1 cycle after input acceptance.
REQ-013 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid && !m_axis_tready.
REQ-014 SHALL assert m_axis_tlast only on pixel PIXELS_PER_BEAT-1 of a word accepted with s_axis_tlast = 1.
REQ-015 SHALL use states EMPTY (no word held) and UNPACK (word held, index 0..PIXELS_PER_BEAT-1); EMPTY->UNPACK on accept; UNPACK->EMPTY when last pixel transfers to output register without a new accept.
REQ-016 SHALL assert s_axis_tready in EMPTY, or in UNPACK when the last pixel moves to the output register this cycle (back-to-back words, no bubble).
REQ-017 SHALL sustain one output pixel per cycle while m_axis_tready stays high and input is available.
REQ-018 SHALL advance the pixel index only when the output register is empty or being consumed in the same cycle.
REQ-019 SHALL handle PIXELS_PER_BEAT = 1 (each word -> one pixel, tlast passed directly).
REQ-020 SHALL never drop, duplicate or reorder pixels under any tvalid/tready pattern.

Reset
REQ-021 SHALL, while resetn = 0, force m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, s_axis_tready = 0, state EMPTY, index 0.
REQ-022 SHALL discard any partially unpacked word when reset asserts mid-operation; first cycle after release s_axis_tready = 1.

Configuration
REQ-023 SHALL, with macro PIXEL_UNPACKER_BYTE_SWAP_EN defined, byte-reverse each PIXEL_WIDTH pixel before expansion (PIXEL_WIDTH must be a multiple of 8, else elaboration error).
REQ-024 SHALL, without PIXEL_UNPACKER_BYTE_SWAP_EN, expand pixels in native bit order with no swap logic.

Verification
REQ-025 Default params, one word 0x0000_0000_0000_1234, tlast=1, m_axis_tready=1 -> four outputs 0x11223344, 0x00000000, 0x00000000, 0x00000000; tlast only on fourth.
REQ-026 Two words back-to-back, tready=1 -> 8 consecutive output beats, s_axis_tready high on the 4th output cycle, zero bubbles.
REQ-027 m_axis_tready toggled 1010... during word 0xFFFF_0F0F_F0F0_ABCD -> 0xAABBCCDD, 0xFF00FF00, 0x00FF00FF, 0xFFFFFFFF, each held stable while stalled.
REQ-028 resetn pulled low after 2 of 4 pixels -> m_axis_tvalid drops asynchronously; after release, next word's pixel 0 emitted first, no residue.
REQ-029 PIXEL_UNPACKER_BYTE_SWAP_EN defined, pixel 0x1234 -> 0x33441122; undefined -> 0x11223344.
REQ-030 SUB_PIXEL_WIDTH=8=CONV_SUB_PIXEL_WIDTH, STREAM_WIDTH=32 -> input 0xDEADBEEF output unchanged, tlast passed through.

Source files
------------

// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
//
// This module unpacks wide AXI-Stream words of reduced-depth pixels into a
// stream of one full-depth pixel per beat.
//
// Each input word holds PIXELS_PER_BEAT pixels, with pixel 0 in the least
// significant bits. Each pixel holds NUMBER_OF_SUB_PIXELS sub-pixels of
// SUB_PIXEL_WIDTH bits. Every sub-pixel is widened to CONV_SUB_PIXEL_WIDTH
// bits by replicating its MSBs into the new low bits.
//
// Ports
//   aclk, resetn          rising-edge clock; asynchronous active-low reset
//   s_axis_tvalid/tready  input handshake
//   s_axis_tlast          input packet end; applies to the word's last pixel
//   s_axis_tdata          packed input word, STREAM_WIDTH bits
//   m_axis_tvalid/tready  output handshake (outputs come from registers)
//   m_axis_tlast          packet end, on the last pixel of a tlast word
//   m_axis_tdata          one expanded pixel,
//                         CONV_SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS bits
//
// Build option
//   PIXEL_UNPACKER_BYTE_SWAP_EN  byte-reverse each pixel before expansion.
//                                PIXEL_WIDTH must be a multiple of 8.
module pixel_stream_unpacker #(
  parameter int SUB_PIXEL_WIDTH      = 4,
  parameter int CONV_SUB_PIXEL_WIDTH = 8,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int STREAM_WIDTH         = 64
) (
  input  logic                                             aclk,
  input  logic                                             resetn,
  input  logic                                             s_axis_tvalid,
  output logic                                             s_axis_tready,
  input  logic                                             s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0]                          s_axis_tdata,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
  output logic                                             m_axis_tlast,
  output logic [CONV_SUB_PIXEL_WIDTH*NUMBER_OF_SUB_PIXELS-1:0] m_axis_tdata
);

  localparam int PIXEL_WIDTH     = SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXELS;
  localparam int OUT_WIDTH       = CONV_SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXELS;
  localparam int PIXELS_PER_BEAT = STREAM_WIDTH / PIXEL_WIDTH;
  localparam int IDX_W           = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_PER_BEAT - 1);

  generate
    if (CONV_SUB_PIXEL_WIDTH < SUB_PIXEL_WIDTH ||
        (STREAM_WIDTH % PIXEL_WIDTH) != 0 || PIXELS_PER_BEAT < 1) begin : g_param_check
      $error("pixel_stream_unpacker: illegal width parameters");
    end
  endgenerate

  typedef enum logic {
    EMPTY  = 1'b0,
    UNPACK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [STREAM_WIDTH-1:0] word_q, word_d;
  logic                    word_last_q, word_last_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;

  logic [PIXEL_WIDTH-1:0]  cur_pix;
  logic [PIXEL_WIDTH-1:0]  src_pix;
  logic                    out_free;
  logic                    move;
  logic                    last_move;
  logic                    accept;

  // MSB replication, generalised: output bit j (counted from the MSB) takes
  // source bit (j mod SUB_PIXEL_WIDTH) (also counted from the MSB). This equals
  // {c, c[MSB -: DIFF]} and reduces to a plain copy when DIFF is 0.
  function automatic logic [OUT_WIDTH-1:0] expand(input logic [PIXEL_WIDTH-1:0] p);
    logic [OUT_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUMBER_OF_SUB_PIXELS; i++) begin
      for (int unsigned j = 0; j < CONV_SUB_PIXEL_WIDTH; j++) begin
        r[i*CONV_SUB_PIXEL_WIDTH + CONV_SUB_PIXEL_WIDTH - 1 - j] =
          p[i*SUB_PIXEL_WIDTH + SUB_PIXEL_WIDTH - 1 - (j % SUB_PIXEL_WIDTH)];
      end
    end
    return r;
  endfunction

  always_comb cur_pix = word_q[idx_q*PIXEL_WIDTH +: PIXEL_WIDTH];

`ifdef PIXEL_UNPACKER_BYTE_SWAP_EN
  generate
    if ((PIXEL_WIDTH % 8) != 0) begin : g_swap_width_check
      $error("pixel_stream_unpacker: byte swap needs PIXEL_WIDTH multiple of 8");
    end
  endgenerate

  function automatic logic [PIXEL_WIDTH-1:0] byte_swap(input logic [PIXEL_WIDTH-1:0] p);
    logic [PIXEL_WIDTH-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < PIXEL_WIDTH/8; b++) begin
      r[b*8 +: 8] = p[(PIXEL_WIDTH/8 - 1 - b)*8 +: 8];
    end
    return r;
  endfunction

  always_comb src_pix = byte_swap(cur_pix);
`else
  always_comb src_pix = cur_pix;
`endif

  // A held pixel moves into the output register whenever that register is
  // empty or being drained this cycle. The last move frees the word buffer,
  // so the next word can be taken in the same cycle (no bubble).
  always_comb begin
    out_free      = !out_valid_q || m_axis_tready;
    move          = (state_q == UNPACK) && out_free;
    last_move     = move && (idx_q == LAST_IDX);
    s_axis_tready = resetn && ((state_q == EMPTY) || last_move);
    accept        = s_axis_tvalid && s_axis_tready;
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    word_last_d = word_last_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = expand(src_pix);
      out_last_d  = word_last_q && (idx_q == LAST_IDX);
      idx_d       = idx_q + 1'b1;
    end else if (m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    if (last_move) begin
      state_d = EMPTY;
      idx_d   = '0;
    end

    if (accept) begin
      state_d     = UNPACK;
      word_d      = s_axis_tdata;
      word_last_d = s_axis_tlast;
      idx_d       = '0;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      word_q      <= '0;
      word_last_q <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      word_last_q <= word_last_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tdata  = out_data_q;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Self-checking bench for pixel_stream_unpacker.
//
// Instance a uses the default parameters. Instance b uses SUB_PIXEL_WIDTH = 8,
// CONV_SUB_PIXEL_WIDTH = 8 and STREAM_WIDTH = 32, so it passes pixels through.
module tb_pixel_stream_unpacker;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic [31:0] m_data;

  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic        b_s_last = 1'b0;
  logic [31:0] b_s_data = '0;
  logic        b_m_valid;
  logic        b_m_ready = 1'b1;
  logic        b_m_last;
  logic [31:0] b_m_data;

  always #5 clk = ~clk;

  pixel_stream_unpacker dut_a (
    .aclk          (clk),
    .resetn        (resetn),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .s_axis_tdata  (s_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last),
    .m_axis_tdata  (m_data)
  );

  pixel_stream_unpacker #(
    .SUB_PIXEL_WIDTH      (8),
    .CONV_SUB_PIXEL_WIDTH (8),
    .NUMBER_OF_SUB_PIXELS (4),
    .STREAM_WIDTH         (32)
  ) dut_b (
    .aclk          (clk),
    .resetn        (resetn),
    .s_axis_tvalid (b_s_valid),
    .s_axis_tready (b_s_ready),
    .s_axis_tlast  (b_s_last),
    .s_axis_tdata  (b_s_data),
    .m_axis_tvalid (b_m_valid),
    .m_axis_tready (b_m_ready),
    .m_axis_tlast  (b_m_last),
    .m_axis_tdata  (b_m_data)
  );

  typedef struct { logic [31:0] data; logic last; } pix_t;
  typedef struct { logic [63:0] data; logic last; } word_t;
  typedef struct { logic [31:0] data; logic last; int cyc; } obs_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  logic  acc;
  pix_t  exp_q[$];
  word_t stim[$];
  obs_t  olog[$];
  int    acc_log[$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  // Reference expansion: each 4-bit nibble c becomes the byte c*17 (0xc -> 0xcc).
  // Nibble i of the packed pixel goes to byte i of the output.
  function automatic logic [31:0] ref_pixel(input logic [15:0] p_in);
    logic [15:0] p;
    logic [31:0] r;
    int unsigned c;
`ifdef PIXEL_UNPACKER_BYTE_SWAP_EN
    p = {p_in[7:0], p_in[15:8]};
`else
    p = p_in;
`endif
    r = '0;
    for (int i = 0; i < 4; i++) begin
      c = (int'(p) >> (4*i)) & 15;
      r = r | 32'((c * 17) << (8*i));
    end
    return r;
  endfunction

  task automatic push_word(input logic [63:0] d, input logic l);
    pix_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = ref_pixel(d[16*k +: 16]);
      e.last = l && (k == 3);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle. Inputs change at the falling edge. Outputs are sampled
  // 1 time unit later, which also shows the handshakes that complete on the
  // next rising edge.
  task automatic step(input logic sv, input logic [63:0] d, input logic sl, input logic mr);
    pix_t e;
    obs_t o;
    @(negedge clk);
    s_valid = sv;
    s_data  = d;
    s_last  = sl;
    m_ready = mr;
    #1;
    cyc++;
    if (hold_prev) begin
      chk("hold_valid", 64'(m_valid), 64'(1'b1));
      chk("hold_data", 64'(m_data), 64'(hold_data));
      chk("hold_last", 64'(m_last), 64'(hold_last));
    end
    hold_prev = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    acc = s_valid && s_ready;
    if (acc) begin
      push_word(s_data, s_last);
      acc_log.push_back(cyc);
    end
    if (m_valid && m_ready) begin
      o.data = m_data;
      o.last = m_last;
      o.cyc  = cyc;
      olog.push_back(o);
      if (exp_q.size() == 0) begin
        chk("spurious_out", 64'(m_valid), 64'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("pix_data", 64'(m_data), 64'(e.data));
        chk("pix_last", 64'(m_last), 64'(e.last));
      end
    end
  endtask

  // Plays stim[] until it is empty and every expected pixel has come out.
  // Ready modes: 0 = always 1, 1 = toggling 1010..., 2 = random.
  // While mode 2 is active, the input valid is also random. Once valid is
  // raised, it stays high until the word is accepted.
  task automatic run(input int mode, input int budget);
    int   n = 0;
    bit   pres = 1'b0;
    logic r;
    while ((stim.size() > 0 || exp_q.size() > 0) && n < budget) begin
      if (!pres && stim.size() > 0)
        pres = (mode != 2) || ($urandom_range(0, 3) != 0);
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = ((n % 2) == 0);
      else                r = ($urandom_range(0, 2) != 0);
      if (pres) step(1'b1, stim[0].data, stim[0].last, r);
      else      step(1'b0, {$urandom, $urandom}, 1'b0, r);
      if (pres && acc) begin
        void'(stim.pop_front());
        pres = 1'b0;
      end
      n++;
    end
    chk("drain_left", 64'(stim.size() + exp_q.size()), 64'(0));
  endtask

  task automatic add_word(input logic [63:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    stim.push_back(w);
  endtask

  logic [63:0] wd;
  logic [31:0] exp_b;
  int          k;

  initial begin
    // Reset state
    #22;
    chk("rst_m_valid", 64'(m_valid), 64'(1'b0));
    chk("rst_m_last", 64'(m_last), 64'(1'b0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1'b0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rel_s_ready", 64'(s_ready), 64'(1'b1));

    // Single word 0x1234 with tlast set; tlast must appear only on the fourth pixel.
    olog.delete();
    add_word(64'h0000_0000_0000_1234, 1'b1);
    run(0, 40);
    chk("w1_count", 64'(olog.size()), 64'(4));
    if (olog.size() == 4) begin
`ifdef PIXEL_UNPACKER_BYTE_SWAP_EN
      chk("w1_p0", 64'(olog[0].data), 64'h3344_1122);
`else
      chk("w1_p0", 64'(olog[0].data), 64'h1122_3344);
`endif
      chk("w1_p1", 64'(olog[1].data), 64'(0));
      chk("w1_p3", 64'(olog[3].data), 64'(0));
      chk("w1_last", 64'({olog[0].last, olog[1].last, olog[2].last, olog[3].last}), 64'(4'b0001));
    end

    // Two words back to back. There must be no bubble. The second word is taken
    // in the cycle that loads the fourth pixel, while the third pixel is on the bus.
    olog.delete();
    acc_log.delete();
    add_word({$urandom, $urandom}, 1'b0);
    add_word({$urandom, $urandom}, 1'b1);
    run(0, 60);
    chk("b2b_count", 64'(olog.size()), 64'(8));
    if (olog.size() == 8 && acc_log.size() == 2) begin
      chk("b2b_span", 64'(olog[7].cyc - olog[0].cyc), 64'(7));
      chk("b2b_accept", 64'(acc_log[1]), 64'(olog[2].cyc));
    end

    // Output ready toggles; the hold checks in step() cover stability while stalled.
    olog.delete();
    add_word(64'hFFFF_0F0F_F0F0_ABCD, 1'b1);
    run(1, 60);
    chk("tog_count", 64'(olog.size()), 64'(4));
    if (olog.size() == 4) begin
`ifdef PIXEL_UNPACKER_BYTE_SWAP_EN
      chk("tog_p0", 64'(olog[0].data), 64'hCCDD_AABB);
`else
      chk("tog_p0", 64'(olog[0].data), 64'hAABB_CCDD);
`endif
      chk("tog_p1", 64'(olog[1].data), 64'hFF00_FF00);
      chk("tog_p2", 64'(olog[2].data), 64'h00FF_00FF);
      chk("tog_p3", 64'(olog[3].data), 64'hFFFF_FFFF);
    end

    // Reset mid-word: the outputs must drop at once, and no residue may follow.
    olog.delete();
    wd = {$urandom, $urandom};
    step(1'b1, wd, 1'b1, 1'b1);
    k = 0;
    while (!acc && k < 10) begin
      step(1'b1, wd, 1'b1, 1'b1);
      k++;
    end
    k = 0;
    while (olog.size() < 2 && k < 20) begin
      step(1'b0, '0, 1'b0, 1'b1);
      k++;
    end
    chk("mid_two_out", 64'(olog.size()), 64'(2));
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'(1'b0));
    chk("mid_rst_data", 64'(m_data), 64'(0));
    chk("mid_rst_ready", 64'(s_ready), 64'(1'b0));
    exp_q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("mid_rel_ready", 64'(s_ready), 64'(1'b1));
    olog.delete();
    wd = {$urandom, $urandom};
    add_word(wd, 1'b0);
    run(0, 40);
    if (olog.size() > 0)
      chk("mid_first_pix", 64'(olog[0].data), 64'(ref_pixel(wd[15:0])));
    else
      chk("mid_first_pix", 64'(olog.size()), 64'(4));

    // Random traffic with random valid and ready.
    for (int i = 0; i < 40; i++) add_word({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    run(2, 3000);
    for (int i = 0; i < 10; i++) add_word({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    run(0, 200);

    // Pass-through instance b: 8-bit to 8-bit sub-pixels, one pixel per word.
    @(negedge clk);
    b_s_valid = 1'b1;
    b_s_data  = 32'hDEAD_BEEF;
    b_s_last  = 1'b1;
    #1;
    chk("b_s_ready", 64'(b_s_ready), 64'(1'b1));
    @(negedge clk);
    b_s_valid = 1'b0;
    b_s_last  = 1'b0;
    k = 0;
    #1;
    while (!b_m_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
`ifdef PIXEL_UNPACKER_BYTE_SWAP_EN
    exp_b = 32'hEFBE_ADDE;
`else
    exp_b = 32'hDEAD_BEEF;
`endif
    chk("b_valid", 64'(b_m_valid), 64'(1'b1));
    chk("b_data", 64'(b_m_data), 64'(exp_b));
    chk("b_last", 64'(b_m_last), 64'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
